// File: rtl/bcd_scan_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter_if
// Groups the count-request inputs and the count/scan outputs of
// bcd_scan_counter so the counter and its user connect through one port.
//
// Signals:
//   inc        count-up request, sampled every cycle
//   dec        count-down request, sampled every cycle
//   clear      synchronous clear of the count
//   value      16-bit BCD count, digit 3 in [15:12] .. digit 0 in [3:0]
//   binary     BCD digit of the currently scanned slot (0 when blanked)
//   anode      active-low digit enable, all high when the slot is blanked
//   digit_sel  index of the currently scanned digit
//   carry      one-cycle pulse on wrap 9999 -> 0000
//   borrow     one-cycle pulse on wrap 0000 -> 9999
//
// Modports:
//   master  drives the requests, observes the count and scan outputs
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface bcd_scan_counter_if;

    logic        inc;
    logic        dec;
    logic        clear;
    logic [15:0] value;
    logic [3:0]  binary;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic        carry;
    logic        borrow;

    modport master (
        output inc,
        output dec,
        output clear,
        input  value,
        input  binary,
        input  anode,
        input  digit_sel,
        input  carry,
        input  borrow
    );

    modport slave (
        input  inc,
        input  dec,
        input  clear,
        output value,
        output binary,
        output anode,
        output digit_sel,
        output carry,
        output borrow
    );

endinterface

// File: rtl/bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// bcd_scan_counter
// Four-digit BCD up/down event counter with a time-multiplexed scanner for a
// common-anode 4-digit display. Feeds the seven_segment decoder through
// bus.binary and selects the lit digit through bus.anode.
//
// Parameters:
//   SCAN_DIV     clock cycles each digit stays active (2 .. 2**20)
//   BLANK_ZEROS  1: blank leading-zero digits (digit 0 is always lit)
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    bcd_scan_counter_if.slave: inc/dec/clear requests in;
//          value, binary, anode, digit_sel, carry, borrow out
// ---------------------------------------------------------------------------
module bcd_scan_counter #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter bit          BLANK_ZEROS = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    bcd_scan_counter_if.slave  bus
);

    localparam int unsigned     SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // -----------------------------------------------------------------------
    // Count register
    // -----------------------------------------------------------------------
    logic [3:0][3:0] cnt_q;
    logic [3:0][3:0] cnt_d;
    logic            carry_q;
    logic            carry_d;
    logic            borrow_q;
    logic            borrow_d;
    logic            step_up;
    logic            step_dn;
    logic            ripple;

    // Simultaneous inc and dec cancel out.
    assign step_up = bus.inc & ~bus.dec;
    assign step_dn = bus.dec & ~bus.inc;

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        ripple   = 1'b0;

        if (bus.clear) begin
            cnt_d = '0;
        end else if (step_up) begin
            // ripple starts as the +1 into digit 0 and survives only past
            // digits that roll over from 9.
            ripple = 1'b1;
            for (int unsigned k = 0; k < 4; k++) begin
                if (ripple) begin
                    if (cnt_q[k[1:0]] >= 4'd9) begin
                        cnt_d[k[1:0]] = 4'd0;
                    end else begin
                        cnt_d[k[1:0]] = cnt_q[k[1:0]] + 4'd1;
                        ripple        = 1'b0;
                    end
                end
            end
            carry_d = ripple;
        end else if (step_dn) begin
            ripple = 1'b1;
            for (int unsigned k = 0; k < 4; k++) begin
                if (ripple) begin
                    if (cnt_q[k[1:0]] == 4'd0) begin
                        cnt_d[k[1:0]] = 4'd9;
                    end else begin
                        cnt_d[k[1:0]] = cnt_q[k[1:0]] - 4'd1;
                        ripple        = 1'b0;
                    end
                end
            end
            borrow_d = ripple;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // -----------------------------------------------------------------------
    // Scan prescaler and digit select; free-running, independent of counting
    // -----------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt    <= '0;
            digit_sel_q <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt    <= '0;
            digit_sel_q <= digit_sel_q + 2'd1;
        end else begin
            scan_cnt    <= scan_cnt + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Leading-zero blanking: digit k is dark when it and all higher digits
    // are zero. Digit 0 is never dark.
    // -----------------------------------------------------------------------
    logic [3:0] digit_zero;
    logic [3:0] blank;
    logic       slot_blank;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            digit_zero[k[1:0]] = (cnt_q[k[1:0]] == 4'd0);
        end
    end

    always_comb begin
        blank = '0;
        if (BLANK_ZEROS) begin
            blank[3] = digit_zero[3];
            blank[2] = digit_zero[2] & blank[3];
            blank[1] = digit_zero[1] & blank[2];
        end
    end

    assign slot_blank = blank[digit_sel_q];

    // -----------------------------------------------------------------------
    // Outputs; scan outputs are combinational from the registers
    // -----------------------------------------------------------------------
    assign bus.value     = cnt_q;
    assign bus.carry     = carry_q;
    assign bus.borrow    = borrow_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.binary    = slot_blank ? 4'h0 : cnt_q[digit_sel_q];
    assign bus.anode     = slot_blank ? 4'hF : ~(4'b0001 << digit_sel_q);

endmodule

// File: tb/tb_bcd_scan_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_counter
// Drives two counters (BLANK_ZEROS = 0 and 1, SCAN_DIV = 4) with identical
// stimulus and compares them every cycle against an arithmetic model: the
// count is a plain integer 0..9999, the scan position is cycles-since-reset
// modulo the refresh period.
// ---------------------------------------------------------------------------
module tb_bcd_scan_counter;

    localparam int unsigned SCAN_DIV = 4;
    localparam int          PERIOD   = 4 * SCAN_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic inc   = 1'b0;
    logic dec   = 1'b0;
    logic clear = 1'b0;

    int checks = 0;
    int errors = 0;

    bcd_scan_counter_if bus_plain ();
    bcd_scan_counter_if bus_blank ();

    assign bus_plain.inc   = inc;
    assign bus_plain.dec   = dec;
    assign bus_plain.clear = clear;
    assign bus_blank.inc   = inc;
    assign bus_blank.dec   = dec;
    assign bus_blank.clear = clear;

    bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .BLANK_ZEROS(1'b0)) dut_plain (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_plain)
    );

    bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .BLANK_ZEROS(1'b1)) dut_blank (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_blank)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    int   p10 [4] = '{1, 10, 100, 1000};
    int   m_count = 0;
    int   m_ticks = 0;
    logic m_carry = 1'b0;
    logic m_borrow = 1'b0;
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_count  = 0;
            m_ticks  = 0;
            m_carry  = 1'b0;
            m_borrow = 1'b0;
            m_valid  = 1'b1;
        end else begin
            m_ticks  = (m_ticks + 1) % PERIOD;
            m_carry  = 1'b0;
            m_borrow = 1'b0;
            if (clear) begin
                m_count = 0;
            end else if (inc && !dec) begin
                m_carry = (m_count == 9999);
                m_count = (m_count + 1) % 10000;
            end else if (dec && !inc) begin
                m_borrow = (m_count == 0);
                m_count  = (m_count + 9999) % 10000;
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((n / p10[k]) % 10);
        return r;
    endfunction

    function automatic bit slot_dark(input bit bz);
        int slot;
        slot = m_ticks / SCAN_DIV;
        return bz && (slot != 0) && (m_count < p10[slot]);
    endfunction

    function automatic logic [3:0] exp_anode(input bit bz);
        int slot;
        slot = m_ticks / SCAN_DIV;
        if (slot_dark(bz)) return 4'hF;
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [3:0] exp_binary(input bit bz);
        int slot;
        slot = m_ticks / SCAN_DIV;
        if (slot_dark(bz)) return 4'h0;
        return 4'((m_count / p10[slot]) % 10);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------- compare process
    always @(negedge clk) begin
        if (m_valid) begin
            check("plain.value",     bus_plain.value,           to_bcd(m_count));
            check("plain.carry",     16'(bus_plain.carry),      16'(m_carry));
            check("plain.borrow",    16'(bus_plain.borrow),     16'(m_borrow));
            check("plain.digit_sel", 16'(bus_plain.digit_sel),  16'(m_ticks / SCAN_DIV));
            check("plain.anode",     16'(bus_plain.anode),      16'(exp_anode(1'b0)));
            check("plain.binary",    16'(bus_plain.binary),     16'(exp_binary(1'b0)));
            check("blank.value",     bus_blank.value,           to_bcd(m_count));
            check("blank.anode",     16'(bus_blank.anode),      16'(exp_anode(1'b1)));
            check("blank.binary",    16'(bus_blank.binary),     16'(exp_binary(1'b1)));
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic cyc(input logic i, input logic d, input logic c);
        inc   = i;
        dec   = d;
        clear = c;
        @(posedge clk);
        #1;
        inc   = 1'b0;
        dec   = 1'b0;
        clear = 1'b0;
    endtask

    task automatic run(input int n, input logic i, input logic d, input logic c);
        repeat (n) cyc(i, d, c);
    endtask

    task automatic align_slot0();
        int n;
        n = 0;
        while (m_ticks != 0 && n < PERIOD + 2) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("align.digit_sel", 16'(bus_plain.digit_sel), 16'd0);
    endtask

    logic [3:0] tab_lit   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] tab_zero  [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    logic [3:0] tab_0050  [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [3:0] bin_1234  [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
    logic [3:0] bin_0050  [4] = '{4'd0, 4'd5, 4'd0, 4'd0};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then scan
        reset = 1'b1;
        run(2, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst.value",     bus_plain.value,           16'h0000);
        check("rst.anode",     16'(bus_plain.anode),      16'b1110);
        check("rst.binary",    16'(bus_plain.binary),     16'd0);
        check("rst.carry",     16'(bus_plain.carry),      16'd0);
        check("rst.borrow",    16'(bus_plain.borrow),     16'd0);
        check("rst.digit_sel", 16'(bus_plain.digit_sel),  16'd0);
        for (int i = 0; i < PERIOD; i++) begin
            check("scan.anode",       16'(bus_plain.anode),  16'(tab_lit[i / SCAN_DIV]));
            check("scan.binary",      16'(bus_plain.binary), 16'd0);
            check("scan.blank_anode", 16'(bus_blank.anode),  16'(tab_zero[i / SCAN_DIV]));
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("scan.wrap_anode", 16'(bus_plain.anode), 16'b1110);

        // BCD carry chain
        run(999, 1'b1, 1'b0, 1'b0);
        check("chain.0999", bus_plain.value, 16'h0999);
        cyc(1'b1, 1'b0, 1'b0);
        check("chain.1000", bus_plain.value, 16'h1000);
        check("chain.no_carry", 16'(bus_plain.carry), 16'd0);
        run(8999, 1'b1, 1'b0, 1'b0);
        check("chain.9999", bus_plain.value, 16'h9999);
        cyc(1'b1, 1'b0, 1'b0);
        check("wrap.value", bus_plain.value, 16'h0000);
        check("wrap.carry", 16'(bus_plain.carry), 16'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("wrap.carry_drop", 16'(bus_plain.carry), 16'd0);

        // Borrow wrap
        cyc(1'b0, 1'b1, 1'b0);
        check("borrow.value", bus_plain.value, 16'h9999);
        check("borrow.pulse", 16'(bus_plain.borrow), 16'd1);
        cyc(1'b0, 1'b1, 1'b0);
        check("borrow.9998", bus_plain.value, 16'h9998);
        check("borrow.drop", 16'(bus_plain.borrow), 16'd0);
        cyc(1'b0, 1'b0, 1'b1);
        run(1000, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("borrow.0999", bus_plain.value, 16'h0999);

        // Simultaneous events
        cyc(1'b0, 1'b0, 1'b1);
        run(42, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("both.value",  bus_plain.value, 16'h0042);
        check("both.carry",  16'(bus_plain.carry),  16'd0);
        check("both.borrow", 16'(bus_plain.borrow), 16'd0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        check("clr_inc.value", bus_plain.value, 16'h0000);
        check("clr_inc.carry", 16'(bus_plain.carry), 16'd0);
        run(7, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        reset = 1'b0;
        check("rst_mid.value",     bus_plain.value,          16'h0000);
        check("rst_mid.anode",     16'(bus_plain.anode),     16'b1110);
        check("rst_mid.binary",    16'(bus_plain.binary),    16'd0);
        check("rst_mid.digit_sel", 16'(bus_plain.digit_sel), 16'd0);
        check("rst_mid.carry",     16'(bus_plain.carry),     16'd0);

        // Scan/data tracking at 1234
        run(1234, 1'b1, 1'b0, 1'b0);
        align_slot0();
        for (int i = 0; i < PERIOD; i++) begin
            check("track.binary", 16'(bus_plain.binary), 16'(bin_1234[i / SCAN_DIV]));
            check("track.blank_anode", 16'(bus_blank.anode), 16'(tab_lit[i / SCAN_DIV]));
            cyc(1'b0, 1'b0, 1'b0);
        end
        align_slot0();
        check("track.pre_inc", 16'(bus_plain.binary), 16'd4);
        cyc(1'b1, 1'b0, 1'b0);
        check("track.post_inc", 16'(bus_plain.binary), 16'd5);
        check("track.anode",    16'(bus_plain.anode),  16'b1110);

        // Blanking at 0050 and 1000
        cyc(1'b0, 1'b0, 1'b1);
        run(50, 1'b1, 1'b0, 1'b0);
        align_slot0();
        for (int i = 0; i < PERIOD; i++) begin
            check("blank50.anode",  16'(bus_blank.anode),  16'(tab_0050[i / SCAN_DIV]));
            check("blank50.binary", 16'(bus_blank.binary), 16'(bin_0050[i / SCAN_DIV]));
            cyc(1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1);
        run(1000, 1'b1, 1'b0, 1'b0);
        align_slot0();
        for (int i = 0; i < PERIOD; i++) begin
            check("blank1000.anode", 16'(bus_blank.anode), 16'(tab_lit[i / SCAN_DIV]));
            cyc(1'b0, 1'b0, 1'b0);
        end

        // Randomized traffic, including occasional mid-run resets
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            reset = (r == 0);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (r > 0 && r < 5));
            reset = 1'b0;
        end
        run(3, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
